// File: rtl/rom_streamer.sv
// rom_streamer: SPI mode-0 flash sequential reader that streams bytes onto a download port.
// Define ROM_STREAMER_FAST_READ_EN for 0x0B fast read with 8 dummy clocks (default: 0x03 read).
`timescale 1ns/1ps
module rom_streamer #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned WR_GAP  = 8
) (
    input  logic        I_CLK,
    input  logic        I_RESET_N,
    input  logic        I_START,
    input  logic [23:0] I_ADDR,
    input  logic [21:0] I_LEN,
    input  logic        I_ABORT,
    input  logic        I_SPI_MISO,
    output logic        O_SPI_CLK,
    output logic        O_SPI_MOSI,
    output logic        O_SPI_CS_N,
    output logic [7:0]  O_DOWNLOAD_DO,
    output logic        O_DOWNLOAD_WR,
    output logic        O_DOWNLOAD_ON,
    output logic        O_BUSY,
    output logic        O_DONE
);
`ifdef ROM_STREAMER_FAST_READ_EN
    localparam logic [7:0] READ_CMD  = 8'h0B;
    localparam bit         FAST_READ = 1'b1;
`else
    localparam logic [7:0] READ_CMD  = 8'h03;
    localparam bit         FAST_READ = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, FINISH} state_t;
    state_t state, state_nx;

    logic [7:0]  div_cnt;
    logic [7:0]  gap_cnt;
    logic [4:0]  bit_cnt;
    logic [21:0] remaining;
    logic [31:0] sr;
    logic [7:0]  rx;
    logic [7:0]  dout;
    logic        sck;
    logic        wr;
    logic        shifting, sck_tick, sck_rise, sck_fall, field_done, wr_fire;

    always_comb begin
        shifting   = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
        sck_tick   = shifting && (div_cnt == 8'(CLK_DIV - 1));
        sck_rise   = sck_tick && !sck;
        sck_fall   = sck_tick && sck;
        // A field ends on the falling edge after its last bit, leaving SCK low.
        field_done = sck_fall && (bit_cnt == ((state == ADDR) ? 5'd23 : 5'd7));
        wr_fire    = (state == HOLD) && (gap_cnt == '0);
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (I_START) state_nx = (I_LEN == '0) ? FINISH : CMD;
            CMD:    if (I_ABORT) state_nx = FINISH;
                    else if (field_done) state_nx = ADDR;
            ADDR:   if (I_ABORT) state_nx = FINISH;
                    else if (field_done) state_nx = FAST_READ ? DUMMY : DATA;
            DUMMY:  if (I_ABORT) state_nx = FINISH;
                    else if (field_done) state_nx = DATA;
            DATA:   if (I_ABORT) state_nx = FINISH;
                    else if (field_done) state_nx = HOLD;
            // A strobe issued together with an abort still completes.
            HOLD:   if (wr_fire) state_nx = (I_ABORT || remaining == 22'd1) ? FINISH : DATA;
                    else if (I_ABORT) state_nx = FINISH;
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        O_SPI_CS_N    = (state == IDLE) || (state == FINISH);
        O_DOWNLOAD_ON = (state != IDLE) && (state != FINISH);
        O_BUSY        = (state != IDLE);
        O_DONE        = (state == FINISH);
        O_SPI_CLK     = sck;
        O_SPI_MOSI    = sr[31];
        O_DOWNLOAD_DO = dout;
        O_DOWNLOAD_WR = wr;
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            sr        <= '0;
            rx        <= '0;
            dout      <= '0;
            sck       <= 1'b0;
            wr        <= 1'b0;
        end else begin
            wr <= 1'b0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
            if (state == IDLE && I_START && I_LEN != '0) begin
                sr        <= {READ_CMD, I_ADDR};
                remaining <= I_LEN;
                gap_cnt   <= '0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                sck       <= 1'b0;
            end
            if (shifting) begin
                div_cnt <= sck_tick ? '0 : div_cnt + 8'd1;
                if (sck_tick) sck <= !sck;
                if (sck_rise && state == DATA) rx <= {rx[6:0], I_SPI_MISO};
                if (sck_fall) begin
                    sr      <= {sr[30:0], 1'b0};
                    bit_cnt <= field_done ? '0 : bit_cnt + 5'd1;
                end
            end
            if (wr_fire) begin
                wr        <= 1'b1;
                dout      <= rx;
                remaining <= remaining - 22'd1;
                gap_cnt   <= 8'(WR_GAP - 1);
            end
            if (state_nx == FINISH) begin
                sck     <= 1'b0;
                sr      <= '0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: table-driven streams against a serial flash model with a byte scoreboard.
`timescale 1ns/1ps
module tb_rom_streamer;
    localparam int unsigned TB_CLK_DIV = 1;
    localparam int unsigned TB_WR_GAP  = 8;
`ifdef ROM_STREAMER_FAST_READ_EN
    localparam logic [7:0] CMD_EXP = 8'h0B;
    localparam int         HDR     = 40;
`else
    localparam logic [7:0] CMD_EXP = 8'h03;
    localparam int         HDR     = 32;
`endif

    logic        clk;
    logic        I_RESET_N, I_START, I_ABORT;
    logic [23:0] I_ADDR;
    logic [21:0] I_LEN;
    logic        miso = 1'b0;
    logic        O_SPI_CLK, O_SPI_MOSI, O_SPI_CS_N;
    logic [7:0]  O_DOWNLOAD_DO;
    logic        O_DOWNLOAD_WR, O_DOWNLOAD_ON, O_BUSY, O_DONE;

    rom_streamer #(.CLK_DIV(TB_CLK_DIV), .WR_GAP(TB_WR_GAP)) dut (
        .I_CLK(clk), .I_RESET_N(I_RESET_N), .I_START(I_START), .I_ADDR(I_ADDR),
        .I_LEN(I_LEN), .I_ABORT(I_ABORT), .I_SPI_MISO(miso),
        .O_SPI_CLK(O_SPI_CLK), .O_SPI_MOSI(O_SPI_MOSI), .O_SPI_CS_N(O_SPI_CS_N),
        .O_DOWNLOAD_DO(O_DOWNLOAD_DO), .O_DOWNLOAD_WR(O_DOWNLOAD_WR),
        .O_DOWNLOAD_ON(O_DOWNLOAD_ON), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h100000: return 8'hA5;
            24'h100001: return 8'h5A;
            24'h100002: return 8'h00;
            24'h100003: return 8'hFF;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
        endcase
    endfunction

    // Flash model: captures cmd+addr on rising SCK, shifts data out on falling SCK.
    logic [31:0] fl_hdr = '0;
    int          fl_cnt = 0;
    logic [7:0]  fl_b;
    int          fl_k;
    int          cs_low_cnt = 0;

    always @(posedge O_SPI_CLK or posedge O_SPI_CS_N) begin
        if (O_SPI_CS_N) fl_cnt = 0;
        else begin
            if (fl_cnt < 32) fl_hdr = {fl_hdr[30:0], O_SPI_MOSI};
            fl_cnt++;
        end
    end

    always @(negedge O_SPI_CLK) begin
        if (!O_SPI_CS_N && fl_cnt >= HDR) begin
            fl_k = fl_cnt - HDR;
            fl_b = flash_byte(fl_hdr[23:0] + 24'(fl_k / 8));
            miso <= fl_b[7 - (fl_k % 8)];
        end
    end

    always @(negedge O_SPI_CS_N) cs_low_cnt++;

    typedef struct {
        logic [23:0] addr;
        logic [21:0] len;
        int          abort_after;
        int          exp_wr;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] sb[$];
    int         checks = 0, failures = 0;
    int         n_wr = 0, n_done = 0, cyc_now = 0, last_wr_cyc = -1000;
    logic       wr_prev = 1'b0, have_do = 1'b0;
    logic [7:0] last_do = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: advance to the falling clock edge and run the scoreboard.
    task automatic tick();
        @(negedge clk);
        cyc_now++;
        if (!I_RESET_N) have_do = 1'b0;
        if (O_DOWNLOAD_WR) begin
            n_wr++;
            check("wr_width", wr_prev, 0);
            check("wr_gap", (cyc_now - last_wr_cyc) >= TB_WR_GAP, 1);
            if (sb.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_data", O_DOWNLOAD_DO, sb.pop_front());
            last_wr_cyc = cyc_now;
            last_do = O_DOWNLOAD_DO;
            have_do = 1'b1;
        end else if (have_do && I_RESET_N) begin
            check("do_stable", O_DOWNLOAD_DO, last_do);
        end
        if (O_DONE) n_done++;
        wr_prev = O_DOWNLOAD_WR;
    endtask

    task automatic run_vec(input vec_t v);
        int wr0, done0, cs0, cyc;
        logic ab;
        for (int i = 0; i < v.exp_wr; i++) sb.push_back(flash_byte(v.addr + 24'(i)));
        wr0 = n_wr; done0 = n_done; cs0 = cs_low_cnt; cyc = 0; ab = 1'b0;
        I_ADDR = v.addr; I_LEN = v.len; I_START = 1'b1;
        do begin
            tick();
            cyc++;
            I_START = 1'b0;
            I_ABORT = 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", O_BUSY, 1);
                check("on_after_start", O_DOWNLOAD_ON, v.len != 0);
                check("cs_n_after_start", O_SPI_CS_N, v.len == 0);
            end
            if (v.abort_after != 0 && !ab && (n_wr - wr0) == v.abort_after) begin
                I_ABORT = 1'b1;
                ab = 1'b1;
            end
        end while (n_done == done0 && cyc < 4000);
        check("done_seen", n_done - done0, 1);
        check("cs_n_at_done", O_SPI_CS_N, 1);
        check("on_at_done", O_DOWNLOAD_ON, 0);
        check("sck_at_done", O_SPI_CLK, 0);
        check("wr_count", n_wr - wr0, v.exp_wr);
        check("sb_empty", sb.size(), 0);
        if (v.len == 0) begin
            check("len0_cs_never_low", cs_low_cnt - cs0, 0);
            check("len0_done_latency", (cyc >= 1) && (cyc <= 2), 1);
        end else begin
            check("mosi_header", fl_hdr, {CMD_EXP, v.addr});
        end
        tick();
        check("done_one_cycle", O_DONE, 0);
        check("busy_idle", O_BUSY, 0);
        sb.delete();
    endtask

    initial begin
        int wr0, done0, cyc;
        vecs[0] = '{24'h100000, 22'd4,  0, 4};
        vecs[1] = '{24'h000010, 22'd3,  0, 3};
        vecs[2] = '{24'h000000, 22'd0,  0, 0};
        vecs[3] = '{24'h200000, 22'd16, 5, 5};
        vecs[4] = '{24'hFFFFFE, 22'd3,  0, 3};

        I_RESET_N = 1'b0; I_START = 1'b0; I_ABORT = 1'b0; I_ADDR = '0; I_LEN = '0;
        #3;
        check("rst_cs_n", O_SPI_CS_N, 1);
        check("rst_sck", O_SPI_CLK, 0);
        check("rst_mosi", O_SPI_MOSI, 0);
        check("rst_do", O_DOWNLOAD_DO, 0);
        check("rst_wr", O_DOWNLOAD_WR, 0);
        check("rst_on", O_DOWNLOAD_ON, 0);
        check("rst_busy", O_BUSY, 0);
        check("rst_done", O_DONE, 0);
        tick(); tick();
        I_RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (3) tick();
        end

        // Reset landing in the middle of the second byte.
        for (int i = 0; i < 8; i++) sb.push_back(flash_byte(24'h300000 + 24'(i)));
        wr0 = n_wr; done0 = n_done; cyc = 0;
        I_ADDR = 24'h300000; I_LEN = 22'd8; I_START = 1'b1;
        do begin
            tick();
            I_START = 1'b0;
            cyc++;
        end while ((n_wr - wr0) < 1 && cyc < 2000);
        check("rst_first_wr", n_wr - wr0, 1);
        repeat (5) tick();
        check("rst_busy_before", O_BUSY, 1);
        #2 I_RESET_N = 1'b0;
        #1;
        check("rst_async_cs_n", O_SPI_CS_N, 1);
        check("rst_async_sck", O_SPI_CLK, 0);
        check("rst_async_busy", O_BUSY, 0);
        check("rst_async_on", O_DOWNLOAD_ON, 0);
        sb.delete();
        repeat (3) tick();
        I_RESET_N = 1'b1;
        repeat (60) tick();
        check("rst_no_wr_after", n_wr - wr0, 1);
        check("rst_no_done", n_done - done0, 0);

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning I_CLK cycles per SCK half-period (legal range 1-255).
REQ-002 SHALL have parameter WR_GAP, default 8, meaning the minimum number of I_CLK cycles between rising edges of successive O_DOWNLOAD_WR pulses (legal range 2-255).
REQ-003 SHALL have port I_CLK, input, 1 bit: the single clock; all logic rises on it.
REQ-004 SHALL have port I_RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I_START, input, 1 bit: single-cycle request to start a stream.
REQ-006 SHALL have port I_ADDR, input, 24 bits: flash byte start address, sampled when I_START is accepted.
REQ-007 SHALL have port I_LEN, input, 22 bits: stream length in bytes, sampled when I_START is accepted.
REQ-008 SHALL have port I_ABORT, input, 1 bit: ends the stream early (the loader's done flag).
REQ-009 SHALL have port I_SPI_MISO, input, 1 bit: flash serial data out.
REQ-010 SHALL have ports O_SPI_CLK, O_SPI_MOSI and O_SPI_CS_N, outputs, 1 bit each: SPI mode 0 master signals.
REQ-011 SHALL have port O_DOWNLOAD_DO, output, 8 bits: the streamed byte.
REQ-012 SHALL have port O_DOWNLOAD_WR, output, 1 bit: one-cycle strobe that qualifies O_DOWNLOAD_DO.
REQ-013 SHALL have port O_DOWNLOAD_ON, output, 1 bit: high for the duration of the stream.
REQ-014 SHALL have port O_BUSY, output, 1 bit: high while not in IDLE.
REQ-015 SHALL have port O_DONE, output, 1 bit: one-cycle pulse when a stream ends.

Function
REQ-016 SHALL implement the states IDLE, CMD, ADDR, DUMMY, DATA, HOLD, FINISH.
REQ-017 SHALL, in IDLE, accept I_START only when I_START=1; I_START SHALL be ignored in every other state.
REQ-018 SHALL, on an accepted I_START with I_LEN=0, go to FINISH without asserting O_SPI_CS_N low or O_DOWNLOAD_ON.
REQ-019 SHALL, on an accepted I_START with I_LEN>0, drive O_SPI_CS_N=0 and O_DOWNLOAD_ON=1 on the next cycle, then enter CMD.
REQ-020 SHALL use SPI mode 0: O_SPI_CLK idles 0; MOSI changes after the falling edge; MISO is sampled at the rising edge; all fields are sent MSB first.
REQ-021 SHALL, in CMD, shift out 8 command bits, then, in ADDR, shift out the 24 bits of I_ADDR.
REQ-022 SHALL, in DATA, assemble 8 MISO bits into a byte, then enter HOLD with O_SPI_CLK stopped low.
REQ-023 SHALL, in HOLD, present the byte on O_DOWNLOAD_DO and pulse O_DOWNLOAD_WR for exactly 1 cycle once the WR_GAP count since the previous pulse has expired; the first pulse SHALL NOT wait for a gap.
REQ-024 SHALL keep O_DOWNLOAD_DO stable from the WR pulse until the next WR pulse.
REQ-025 SHALL decrement the 22-bit remaining count once per WR pulse; when the count reaches 0, go to FINISH, otherwise resume DATA.
REQ-026 SHALL keep O_SPI_CS_N low across HOLD so that the flash continues its sequential read; there SHALL be no re-addressing.
REQ-027 SHALL, when I_ABORT=1 in any non-IDLE state, go to FINISH on the next cycle, and a byte in HOLD not yet strobed SHALL NOT be strobed.
REQ-028 SHALL, if I_ABORT and a WR pulse fall on the same cycle, let that WR pulse complete before going to FINISH.
REQ-029 SHALL, in FINISH, drive O_SPI_CS_N=1, O_SPI_CLK=0 and O_DOWNLOAD_ON=0, pulse O_DONE for 1 cycle, then return to IDLE.
REQ-030 SHALL let the flash address wrap modulo 2^24 (flash-internal behaviour); no special handling is required.

Reset
REQ-031 SHALL, while I_RESET_N=0, immediately (asynchronously) force: state=IDLE, O_SPI_CS_N=1, O_SPI_CLK=0, O_SPI_MOSI=0, O_DOWNLOAD_DO=0, O_DOWNLOAD_WR=0, O_DOWNLOAD_ON=0, O_BUSY=0, O_DONE=0, and all counters to 0.
REQ-032 SHALL, on reset asserted mid-stream, produce no O_DONE pulse and emit no further WR pulse after reset is released.

Configuration
REQ-033 SHALL, with macro ROM_STREAMER_FAST_READ_EN defined, use command 0x0B and pass through DUMMY (8 SCK cycles, MOSI=0) between ADDR and DATA.
REQ-034 SHALL, without ROM_STREAMER_FAST_READ_EN defined, use command 0x03 and skip DUMMY.

Verification
REQ-035 SHALL cover the scenario: I_ADDR=0x100000, I_LEN=4, flash model returns A5,5A,00,FF -> MOSI carries 03 10 00 00; exactly 4 WR pulses with DO=A5,5A,00,FF; then O_DONE pulse and CS_N=1.
REQ-036 SHALL cover the scenario: WR_GAP=8, CLK_DIV=1, I_LEN=3 -> consecutive WR rising edges are at least 8 cycles apart and each WR is 1 cycle wide.
REQ-037 SHALL cover the scenario: I_LEN=0 -> CS_N stays 1, no WR pulse, O_DONE is pulsed 1-2 cycles after I_START.
REQ-038 SHALL cover the scenario: I_LEN=16 with I_ABORT pulsed after the 5th WR -> exactly 5 WR pulses, then O_DONE, then O_DOWNLOAD_ON=0.
REQ-039 SHALL cover the scenario: I_RESET_N=0 during DATA of byte 2 -> CS_N=1 within the same cycle, no O_DONE, no WR after release; I_START still works afterwards.
REQ-040 SHALL cover the scenario: ROM_STREAMER_FAST_READ_EN defined -> MOSI carries 0B plus the address, 8 dummy clocks precede the first data bit, and the bytes match the 0x03-mode run.
